// File: rtl/mem_bus_arbiter.sv
// Arbitrates a fetch port and a load/store port onto one shared single-outstanding memory port.
// Optional feature macro: ARB_STARVATION_GUARD_EN bounds how long data traffic may starve fetches.
module mem_bus_arbiter #(
  parameter int unsigned STARVATION_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_req_i,
  input  logic        instr_flush_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_rsp_o,
  output logic [31:0] instr_data_o,
  input  logic        data_rd_i,
  input  logic        data_wr_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  input  logic [3:0]  data_wstrb_i,
  output logic        data_rsp_o,
  output logic [31:0] data_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);
  localparam int unsigned AW      = 32;
  localparam int unsigned DW      = 32;
  localparam int unsigned SW      = 4;
  localparam int unsigned CW      = 4;
  localparam int unsigned CNT_MAX = 15;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    INSTR   = 2'd1,
    DATA    = 2'd2,
    DISCARD = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [SW-1:0] mem_wstrb_q, mem_wstrb_d;
  logic          instr_rsp_q, instr_rsp_d;
  logic [DW-1:0] instr_data_q, instr_data_d;
  logic          data_rsp_q, data_rsp_d;
  logic [DW-1:0] data_rdata_q, data_rdata_d;

  logic [CW-1:0] starve_cnt;
  logic          starve_c;
  logic          grant_data_c;
  logic          grant_instr_c;

  // Data has priority unless a waiting fetch has been passed over too often.
  assign starve_c      = instr_req_i && (starve_cnt >= CW'(STARVATION_LIMIT));
  assign grant_data_c  = (state_q == IDLE) && (data_rd_i || data_wr_i) && !starve_c;
  assign grant_instr_c = (state_q == IDLE) && instr_req_i && !grant_data_c;

`ifdef ARB_STARVATION_GUARD_EN
  logic [CW-1:0] starve_cnt_q, starve_cnt_d;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (grant_instr_c) begin
      starve_cnt_d = '0;
    end else if (grant_data_c && instr_req_i && (starve_cnt_q != CW'(CNT_MAX))) begin
      starve_cnt_d = starve_cnt_q + CW'(1);
    end
  end

  assign starve_cnt = starve_cnt_q;
`else
  assign starve_cnt = '0;
`endif

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wstrb_d  = mem_wstrb_q;
    instr_rsp_d  = 1'b0;
    instr_data_d = instr_data_q;
    data_rsp_d   = 1'b0;
    data_rdata_d = data_rdata_q;

    case (state_q)
      IDLE: begin
        if (grant_data_c) begin
          state_d     = DATA;
          mem_req_d   = 1'b1;
          mem_we_d    = data_wr_i;
          mem_addr_d  = data_addr_i;
          mem_wdata_d = data_wdata_i;
          mem_wstrb_d = data_wstrb_i;
        end else if (grant_instr_c) begin
          state_d     = INSTR;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = instr_addr_i;
          mem_wstrb_d = '0;
        end
      end
      INSTR: begin
        if (mem_ack_i) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          if (!instr_flush_i) begin
            instr_rsp_d  = 1'b1;
            instr_data_d = mem_rdata_i;
          end
        end else if (instr_flush_i) begin
          state_d = DISCARD;
        end
      end
      DATA: begin
        if (mem_ack_i) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          data_rsp_d = 1'b1;
          if (!mem_we_q) begin
            data_rdata_d = mem_rdata_i;
          end
        end
      end
      DISCARD: begin
        // The memory still owes an ack; absorb it without answering the fetch.
        if (mem_ack_i) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wstrb_q  <= '0;
      instr_rsp_q  <= 1'b0;
      instr_data_q <= '0;
      data_rsp_q   <= 1'b0;
      data_rdata_q <= '0;
`ifdef ARB_STARVATION_GUARD_EN
      starve_cnt_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
      instr_rsp_q  <= instr_rsp_d;
      instr_data_q <= instr_data_d;
      data_rsp_q   <= data_rsp_d;
      data_rdata_q <= data_rdata_d;
`ifdef ARB_STARVATION_GUARD_EN
      starve_cnt_q <= starve_cnt_d;
`endif
    end
  end

  assign mem_req_o    = mem_req_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign mem_wstrb_o  = mem_wstrb_q;
  assign instr_rsp_o  = instr_rsp_q;
  assign instr_data_o = instr_data_q;
  assign data_rsp_o   = data_rsp_q;
  assign data_rdata_o = data_rdata_q;

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter: STARVATION_LIMIT, 4, max consecutive data grants while instruction waits (range 1-15).
REQ-002 SHALL have ports:
- clk  in  1  single clock; all flops rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr_req_i  in  1  fetch request, level.
- instr_flush_i  in  1  fetch abandons outstanding request.
- instr_addr_i  in  32  fetch address.
- instr_rsp_o  out  1  fetch response pulse.
- instr_data_o  out  32  fetched word, valid with instr_rsp_o.
- data_rd_i  in  1  load request, level.
- data_wr_i  in  1  store request, level.
- data_addr_i  in  32  load/store address.
- data_wdata_i  in  32  store data.
- data_wstrb_i  in  4  store byte enables.
- data_rsp_o  out  1  load/store completion pulse.
- data_rdata_o  out  32  load data, valid with data_rsp_o.
- mem_req_o  out  1  shared port request, held until ack.
- mem_we_o  out  1  shared port write enable.
- mem_addr_o  out  32  shared port address.
- mem_wdata_o  out  32  shared port write data.
- mem_wstrb_o  out  4  shared port byte enables.
- mem_ack_i  in  1  shared port completion, one-cycle pulse.
- mem_rdata_i  in  32  shared port read data, valid with mem_ack_i.

Function
REQ-003 SHALL implement FSM states IDLE, INSTR, DATA, DISCARD.
REQ-004 IDLE: data_rd_i|data_wr_i -> DATA; else instr_req_i -> INSTR; arbitration decision and mem_* outputs registered, so mem_req_o rises the cycle after request sampled.
REQ-005 mem_addr_o, mem_we_o, mem_wdata_o, mem_wstrb_o SHALL be captured at grant and held stable while mem_req_o=1.
REQ-006 data_rd_i and data_wr_i both high: write wins; data_rsp_o pulses once.
REQ-007 INSTR/DATA: on mem_ack_i, mem_req_o drops same edge; state -> IDLE; requester's rsp pulses one cycle later with mem_rdata_i registered into its data output.
REQ-008 Throughput: one transaction per 2 cycles minimum (grant cycle + ack); no back-to-back grant without passing IDLE.
REQ-009 instr_flush_i in INSTR without mem_ack_i -> DISCARD; DISCARD keeps mem_req_o until mem_ack_i, then IDLE with no instr_rsp_o.
REQ-010 instr_flush_i in same cycle as mem_ack_i -> instr_rsp_o suppressed; instr_flush_i in IDLE -> no effect.
REQ-011 Requester dropping request while granted SHALL NOT abort the memory transaction; response still issued.
REQ-012 data_rsp_o and instr_rsp_o SHALL never be high in the same cycle.
REQ-013 Write transactions: data_rdata_o SHALL hold its previous value.

Reset
REQ-014 rst_n=0 asynchronously forces IDLE; mem_req_o, mem_we_o, instr_rsp_o, data_rsp_o = 0; mem_addr_o, mem_wdata_o, instr_data_o, data_rdata_o = 32'h0; mem_wstrb_o = 4'h0; starvation counter = 0.
REQ-015 Reset mid-transaction SHALL abandon it; a mem_ack_i arriving after deassertion while IDLE SHALL be ignored.

Configuration
REQ-016 Macro ARB_STARVATION_GUARD_EN defined: 4-bit counter increments per data grant while instr_req_i=1, clears on instruction grant; counter >= STARVATION_LIMIT forces instruction grant in IDLE.
REQ-017 Macro undefined: strict data priority, no counter flops.

Verification
REQ-018 Single fetch, addr 32'h100, ack 2 cycles after mem_req_o with rdata 32'h00000013 -> instr_rsp_o one cycle after ack, instr_data_o=32'h00000013.
REQ-019 instr_req_i and data_wr_i asserted together, addr 32'h2000, wdata 32'hDEADBEEF, wstrb 4'hF -> data granted first with mem_we_o=1, instruction granted after return to IDLE.
REQ-020 Fetch granted, instr_flush_i pulsed before ack -> mem_req_o held to ack, no instr_rsp_o, next request granted from IDLE.
REQ-021 Guard enabled, STARVATION_LIMIT=4, data_rd_i held high with instr_req_i high -> 4 data grants, then one instruction grant, counter cleared.
REQ-022 rst_n pulsed low while mem_req_o=1 -> all outputs zero immediately; late mem_ack_i produces no response.
